// File: rtl/eq_dac_pacer.sv
// Paced DAC output stage: FIFO-buffered equalizer samples, released once per DIV clocks,
// shifted, saturated and offset-binary coded. Define DAC_INVERT_EN for inverted DAC codes.
module eq_dac_pacer #(
  parameter int unsigned DIN_W   = 29,
  parameter int unsigned DOUT_W  = 10,
  parameter int unsigned SHIFT   = 9,
  parameter int unsigned DIV     = 1250,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic [DOUT_W-1:0] dac_dat,
  output logic              dac_upd,
  output logic              underrun,
  output logic [7:0]        ovf_cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [FIFO_AW:0] OCC_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] OCC_HALF = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic signed [DIN_W-1:0] S_MAX = DIN_W'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [DIN_W-1:0] S_MIN = ~S_MAX;
`ifdef DAC_INVERT_EN
  localparam logic [DOUT_W-1:0] MID = {1'b0, {(DOUT_W - 1){1'b1}}};
`else
  localparam logic [DOUT_W-1:0] MID = {1'b1, {(DOUT_W - 1){1'b0}}};
`endif

  typedef enum logic {StPrefill, StRun} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic               tick;
  logic [DIN_W-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   occ_q;
  logic               push, pop, drop;
  logic               upd_d, und_d;
  logic [DOUT_W-1:0]  dac_dat_q, code;
  logic               dac_upd_q, underrun_q;
  logic [7:0]         ovf_q;
  logic signed [DIN_W-1:0] head, shifted;

  // Free-running sample-rate divider; never restarted by the FSM.
  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || tick) cnt_q <= '0;
    else                 cnt_q <= cnt_q + CNT_W'(1);
  end

  // Readiness is based on occupancy at the start of the cycle, so a pop never frees room
  // for a same-cycle push when full.
  assign din_rdy = (occ_q != OCC_FULL);
  assign push    = din_vld && din_rdy;
  assign drop    = din_vld && !din_rdy;

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + (FIFO_AW + 1)'(1);
        2'b01:   occ_q <= occ_q - (FIFO_AW + 1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    upd_d   = 1'b0;
    und_d   = 1'b0;
    unique case (state_q)
      StPrefill: begin
        if (occ_q >= OCC_HALF) state_d = StRun;
      end
      StRun: begin
        if (tick) begin
          if (occ_q != '0) begin
            pop   = 1'b1;
            upd_d = 1'b1;
          end else begin
            und_d   = 1'b1;
            state_d = StPrefill;
          end
        end
      end
      default: state_d = StPrefill;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= StPrefill;
    else         state_q <= state_d;
  end

  // Full-width arithmetic shift and clamp; offset binary is the clamped value with MSB flipped.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    shifted = head >>> SHIFT;
    if (shifted > S_MAX)      code = '1;
    else if (shifted < S_MIN) code = '0;
    else                      code = {~shifted[DOUT_W-1], shifted[DOUT_W-2:0]};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dac_dat_q  <= MID;
      dac_upd_q  <= 1'b0;
      underrun_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
`ifdef DAC_INVERT_EN
      if (pop) dac_dat_q <= ~code;
`else
      if (pop) dac_dat_q <= code;
`endif
      dac_upd_q  <= upd_d;
      underrun_q <= und_d;
      if (drop && ovf_q != 8'hff) ovf_q <= ovf_q + 8'd1;
    end
  end

  assign dac_dat  = dac_dat_q;
  assign dac_upd  = dac_upd_q;
  assign underrun = underrun_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_eq_dac_pacer.sv
// Directed bench for eq_dac_pacer: pacing, saturation, overflow, underrun and reset recovery.
module tb_eq_dac_pacer;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [9:0]  dac_dat;
  logic        dac_upd;
  logic        underrun;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;

  eq_dac_pacer dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dac_dat  (dac_dat),
    .dac_upd  (dac_upd),
    .underrun (underrun),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int xc(input int c);
`ifdef DAC_INVERT_EN
    return 1023 - c;
`else
    return c;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int v);
    din     = v[28:0];
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
  endtask

  // Steps until dac_upd (sel=0) or underrun (sel=1) is seen, at most budget cycles.
  task automatic wait_evt(input bit sel, input int budget, output int n, output bit found);
    n     = 0;
    found = 1'b0;
    while (n < budget && !found) begin
      step();
      n++;
      if ((sel ? underrun : dac_upd) == 1'b1) found = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int  n;
  bit  found;
  int  sat_in  [8];
  int  sat_exp [8];

  initial begin
    sat_in  = '{32'sd134217728, -32'sd134217728, 511 << 9, -(512 << 9), -1,
                (100 << 9) + 300, -(3 << 9) - 1, 32'sd268435455};
    sat_exp = '{1023, 0, 1023, 0, 511, 612, 508, 1023};

    rst     = 1'b1;
    din     = '0;
    din_vld = 1'b0;
    step();
    step();
    check_val("rst_dac_dat", dac_dat, xc(512));
    check_val("rst_dac_upd", dac_upd, 0);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_ovf_cnt", ovf_cnt, 0);
    check_val("rst_din_rdy", din_rdy, 1);
    rst = 1'b0;

    // Basic pacing: four zeros, first update 1250 cycles after reset release.
    for (int i = 0; i < 4; i++) push_one(0);
    wait_evt(1'b0, 3000, n, found);
    check_val("first_upd_found", found, 1);
    check_val("first_upd_latency", n + 4, 1250);
    check_val("first_upd_dat", dac_dat, xc(512));
    for (int i = 0; i < 3; i++) begin
      wait_evt(1'b0, 3000, n, found);
      check_val("upd_period", n, 1250);
      check_val("upd_dat_zero", dac_dat, xc(512));
    end
    wait_evt(1'b1, 3000, n, found);
    check_val("und_zero_period", n, 1250);
    check_val("und_zero_no_upd", dac_upd, 0);

    // Saturation and rounding toward minus infinity.
    do_reset();
    for (int i = 0; i < 8; i++) push_one(sat_in[i]);
    for (int i = 0; i < 8; i++) begin
      wait_evt(1'b0, 3000, n, found);
      check_val("sat_found", found, 1);
      check_val($sformatf("sat_code%0d", i), dac_dat, xc(sat_exp[i]));
    end

    // Overflow: ten back-to-back pushes, two dropped.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      push_one(k << 9);
      if (k == 7) check_val("ovf_rdy_at7", din_rdy, 1);
      if (k == 8) check_val("ovf_rdy_at8", din_rdy, 0);
    end
    check_val("ovf_cnt_two", ovf_cnt, 2);
    for (int k = 1; k <= 8; k++) begin
      wait_evt(1'b0, 3000, n, found);
      check_val("ovf_upd_found", found, 1);
      check_val($sformatf("ovf_order%0d", k), dac_dat, xc(512 + k));
    end

    // Underrun after draining, then refill resumes.
    wait_evt(1'b1, 3000, n, found);
    check_val("und_found", found, 1);
    check_val("und_period", n, 1250);
    check_val("und_hold", dac_dat, xc(520));
    for (int k = 20; k < 24; k++) push_one(k << 9);
    wait_evt(1'b0, 3000, n, found);
    check_val("refill_latency", n, 1246);
    check_val("refill_dat", dac_dat, xc(532));

    // Reset mid-RUN with three samples queued.
    do_reset();
    check_val("mid_rst_dat", dac_dat, xc(512));
    check_val("mid_rst_upd", dac_upd, 0);
    check_val("mid_rst_und", underrun, 0);
    check_val("mid_rst_ovf", ovf_cnt, 0);
    check_val("mid_rst_rdy", din_rdy, 1);
    wait_evt(1'b0, 1400, n, found);
    check_val("mid_rst_no_upd", found, 0);
    push_one(-(5 << 9));
    for (int i = 0; i < 3; i++) push_one(0);
    wait_evt(1'b0, 3000, n, found);
    check_val("post_rst_found", found, 1);
    check_val("post_rst_dat", dac_dat, xc(507));

    // Overflow counter saturates at 255.
    do_reset();
    din     = '0;
    din_vld = 1'b1;
    for (int i = 0; i < 300; i++) step();
    din_vld = 1'b0;
    check_val("ovf_sat", ovf_cnt, 255);
    check_val("ovf_sat_rdy", din_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
